lsu_master: RTL
===============

# lsu_master

Load/store initiator between the M-stage pipeline and the data-memory bus. It latches one load or store per request and generates the word-aligned bus address, byte enables and lane-shifted store data. It holds the bus request until the memory acknowledges, then returns sign- or zero-extended load data. It stalls the pipeline while the access is in flight and reports address-error and bus-timeout exceptions with the faulting PC.

## Interface
- BUS_TIMEOUT, 255: max cycles in BUS state before a bus error (1..65535)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (reset==0 resets on the rising edge)
- req_valid  in  1  M-stage access request
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word; 3 is reserved and treated as word
- req_unsigned  in  1  zero-extend load (lbu/lhu)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_pc  in  32  PC of the instruction
- stall  out  1  pipeline hold
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores)
- exc_valid  out  1  one-cycle exception pulse
- exc_code  out  5  4=AdEL, 5=AdES, 7=DBE
- exc_pc  out  32  latched req_pc
- exc_badaddr  out  32  latched req_addr
- bus_req  out  1  memory request
- bus_we  out  1  write strobe
- bus_addr  out  32  {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-aligned store data
- bus_ack  in  1  memory accepts write / read data valid
- bus_rdata  in  32  read word

## Operation
- States: IDLE, BUS, RESP, EXC.
- IDLE, req_valid=1, aligned -> latch all req_* fields and go to BUS.
- IDLE, req_valid=1, misaligned -> latch all req_* fields and go to EXC. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
- BUS, bus_ack=1 -> capture bus_rdata and go to RESP.
- BUS, timeout counter reaches BUS_TIMEOUT-1 without ack -> go to EXC with code 7.
- RESP and EXC last exactly one cycle, then return to IDLE.
- Byte enables:
  - Byte: be = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - Half: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}.
  - Word: be = 4'b1111, wdata unchanged.
- Loads:
  - Byte lane is selected by addr[1:0]; half lane is selected by addr[1].
  - Extension is sign unless req_unsigned=1.
  - req_unsigned is ignored for word loads.
- bus_we = latched req_we. bus_be is driven for loads too; memory may ignore it.
- Timeout counter clears on entry to BUS. It saturates and never wraps.

## Timing
- Reset values: state=IDLE, all outputs 0, counter 0, latched fields 0.
- Reset mid-operation: the access is abandoned immediately, bus_req drops in the next cycle, and no resp_valid or exc_valid pulse is produced.
- stall = (state==BUS) | (state==IDLE & req_valid). This is combinational, so the requesting instruction holds until RESP or EXC.
- stall=0 in RESP and EXC. The pipeline advances on that cycle, with resp_rdata or exc_* valid.
- bus_* outputs are registered. bus_req=1 exactly while in BUS, and all bus_* outputs are stable until ack.
- Minimum latency, request to resp_valid: 2 cycles for zero-wait memory (IDLE->BUS ack->RESP).
- req_valid is not sampled in BUS, RESP or EXC. A request present during RESP is accepted in the following IDLE cycle.
- An ack arriving on the same cycle the timeout fires wins: the access completes normally.
- bus_ack outside BUS is ignored.

## Configuration
- LSU_ALIGN_CHECK_EN defined: misaligned requests raise AdEL or AdES as described above, with no bus traffic.
- LSU_ALIGN_CHECK_EN undefined:
  - Half/word accesses force the low address bits to 0, i.e. {addr[31:2],2'b00} for word and addr[0]=0 for half.
  - The access proceeds to BUS, and codes 4 and 5 are never produced.

## Test plan
- Store byte: addr 0x0000_0013, wdata 0x0000_00AB -> one-cycle bus_req with bus_addr 0x10, be 4'b1000, bus_wdata 0xABABABAB, then resp_valid one cycle after ack.
- Load half signed, addr 0x6, bus_rdata 0x8001_7FFF -> resp_rdata 0xFFFF_8001. Repeated with req_unsigned=1 -> 0x0000_8001.
- Load word with ack delayed 5 cycles -> stall held 6 cycles, bus_* stable throughout, resp_rdata equals bus_rdata.
- Word load at addr 0x2 with LSU_ALIGN_CHECK_EN -> no bus_req, exc_valid with code 4, exc_badaddr 0x2, exc_pc equal to req_pc. Without the macro -> bus_addr 0x0, normal response.
- BUS_TIMEOUT=4 with no ack -> exc_code 7 after 4 BUS cycles, bus_req drops. Separately, ack on the 4th cycle -> normal RESP.
- reset=0 asserted during BUS -> next cycle state IDLE, bus_req=0, stall=0, no resp_valid or exc_valid pulse.

Source files
------------

// File: rtl/lsu_master.sv
// Load/store initiator between the M-stage pipeline and the data-memory bus.
// Optional alignment exceptions are enabled with `define LSU_ALIGN_CHECK_EN.
module lsu_master #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_pc,
  output logic [31:0] exc_badaddr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {StIdle, StBus, StResp, StExc} state_e;

  localparam logic [15:0] TimeoutLast = 16'(BUS_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  logic        is_word, is_half;
  logic [31:0] addr_eff;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
`ifdef LSU_ALIGN_CHECK_EN
  logic        misalign;
`endif

  always_comb begin
    is_word = req_size[1];
    is_half = (req_size == 2'd1);
`ifdef LSU_ALIGN_CHECK_EN
    misalign = (is_half & req_addr[0]) | (is_word & (req_addr[1:0] != 2'b00));
    addr_eff = req_addr;
`else
    // Without alignment checks the offending low bits are simply dropped.
    if (is_word)      addr_eff = {req_addr[31:2], 2'b00};
    else if (is_half) addr_eff = {req_addr[31:1], 1'b0};
    else              addr_eff = req_addr;
`endif
    if (is_word) begin
      be_new    = 4'b1111;
      wdata_new = req_wdata;
    end else if (is_half) begin
      be_new    = addr_eff[1] ? 4'b1100 : 4'b0011;
      wdata_new = {2{req_wdata[15:0]}};
    end else begin
      be_new    = 4'b0001 << addr_eff[1:0];
      wdata_new = {4{req_wdata[7:0]}};
    end
  end

  // Load lane selection and extension use the latched request fields.
  always_comb begin
    ld_byte = 8'(bus_rdata >> {addr_q[1:0], 3'b000});
    ld_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      2'd0:    ld_ext = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'd1:    ld_ext = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    pc_d        = pc_q;
    code_d      = code_q;
    rdata_d     = rdata_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d        = req_we;
          size_d      = req_size;
          uns_d       = req_unsigned;
          addr_d      = req_addr;
          pc_d        = req_pc;
          bus_we_d    = req_we;
          bus_addr_d  = {addr_eff[31:2], 2'b00};
          bus_be_d    = be_new;
          bus_wdata_d = wdata_new;
          cnt_d       = 16'd0;
          state_d     = StBus;
`ifdef LSU_ALIGN_CHECK_EN
          if (misalign) begin
            code_d  = req_we ? 5'd5 : 5'd4;
            state_d = StExc;
          end
`endif
        end
      end
      StBus: begin
        // Ack beats a timeout firing in the same cycle.
        if (bus_ack) begin
          rdata_d = we_q ? 32'h0 : ld_ext;
          state_d = StResp;
        end else if (cnt_q == TimeoutLast) begin
          code_d  = 5'd7;
          state_d = StExc;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StResp:  state_d = StIdle;
      StExc:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    bus_req_d = (state_d == StBus);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 16'd0;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      addr_q      <= 32'h0;
      pc_q        <= 32'h0;
      code_q      <= 5'd0;
      rdata_q     <= 32'h0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      pc_q        <= pc_d;
      code_q      <= code_d;
      rdata_q     <= rdata_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign stall       = (state_q == StBus) | ((state_q == StIdle) & req_valid);
  assign resp_valid  = (state_q == StResp);
  assign exc_valid   = (state_q == StExc);
  assign resp_rdata  = rdata_q;
  assign exc_code    = code_q;
  assign exc_pc      = pc_q;
  assign exc_badaddr = addr_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_be      = bus_be_q;
  assign bus_wdata   = bus_wdata_q;

endmodule
